// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults for the register file and its scoreboard
package regfile_sb_pkg;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_ZERO_REG = 1;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits, busy count and operand stall for multi-cycle producers
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_cnt
);
  logic h0, h1, set, inc, dec;
  // hazards ignore a register being written this cycle; issue is gated by stall
  always_comb begin
    h0    = busy_vec[ra0] && !(we && wa == ra0) && !(ZERO_REG != 0 && ra0 == '0);
    h1    = busy_vec[ra1] && !(we && wa == ra1) && !(ZERO_REG != 0 && ra1 == '0);
    stall = h0 || h1;
    set   = issue_valid && !stall && !(ZERO_REG != 0 && issue_rd == '0);
    inc   = set && !busy_vec[issue_rd];
    dec   = we && busy_vec[wa] && !(set && issue_rd == wa);
  end
  // set after clear so a new producer supersedes the completing one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      if (we) busy_vec[wa] <= 1'b0;
      if (set) busy_vec[issue_rd] <= 1'b1;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R+1W+debug register file with hardwired x0, write bypass and busy scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [WIDTH-1:0]  rd0,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  dbg_rd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [WIDTH-1:0] regs [DEPTH];
  // storage; writes to x0 are dropped when it is hardwired
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && !(ZERO_REG != 0 && wa == '0)) begin
      regs[wa] <= wdata;
    end
  end
  // operand ports bypass the in-flight write; debug port shows stored state only
  always_comb begin
    rd0    = (ZERO_REG != 0 && ra0 == '0) ? '0 : (we && wa == ra0) ? wdata : regs[ra0];
    rd1    = (ZERO_REG != 0 && ra1 == '0) ? '0 : (we && wa == ra1) ? wdata : regs[ra1];
    dbg_rd = (ZERO_REG != 0 && dbg_ra == '0) ? '0 : regs[dbg_ra];
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .ra0(ra0), .ra1(ra1),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall), .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb in 32x5 and 64x4 configurations
module tb_regfile_sb;
  logic        clk = 0;
  logic        reset = 0;
  logic        we = 0;
  logic [4:0]  wa = 0;
  logic [63:0] wdata = 0;
  logic [4:0]  ra0 = 0, ra1 = 0, dbg_ra = 0;
  logic        issue_valid = 0;
  logic [4:0]  issue_rd = 0;
  logic [31:0] rd0_a, rd1_a, dbg_a;
  logic        stall_a;
  logic [31:0] busy_a;
  logic [5:0]  cnt_a;
  logic [63:0] rd0_b, rd1_b, dbg_b;
  logic        stall_b;
  logic [15:0] busy_b;
  logic [4:0]  cnt_b;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  m;
    logic [63:0] rd0, rd1, dbg;
    logic        stall;
    logic [31:0] busy;
    int          cnt;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wdata(wdata[31:0]),
    .ra0(ra0), .ra1(ra1), .dbg_ra(dbg_ra), .rd0(rd0_a), .rd1(rd1_a), .dbg_rd(dbg_a),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall_a), .busy_vec(busy_a), .busy_cnt(cnt_a)
  );

  regfile_sb #(.WIDTH(64), .ADDR_W(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa[3:0]), .wdata(wdata),
    .ra0(ra0[3:0]), .ra1(ra1[3:0]), .dbg_ra(dbg_ra[3:0]), .rd0(rd0_b), .rd1(rd1_b), .dbg_rd(dbg_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd[3:0]),
    .stall(stall_b), .busy_vec(busy_b), .busy_cnt(cnt_b)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: one expectation per sampled cycle, checked on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) cmp({e.name, ".a.rd0"}, 64'(rd0_a), {32'b0, e.rd0[31:0]});
      if (e.m[1]) cmp({e.name, ".a.rd1"}, 64'(rd1_a), {32'b0, e.rd1[31:0]});
      if (e.m[2]) cmp({e.name, ".a.dbg"}, 64'(dbg_a), {32'b0, e.dbg[31:0]});
      cmp({e.name, ".a.stall"}, 64'(stall_a), 64'(e.stall));
      cmp({e.name, ".a.busy"}, 64'(busy_a), 64'(e.busy));
      cmp({e.name, ".a.cnt"}, 64'(cnt_a), 64'(e.cnt));
      if (e.m[0]) cmp({e.name, ".b.rd0"}, rd0_b, e.rd0);
      if (e.m[1]) cmp({e.name, ".b.rd1"}, rd1_b, e.rd1);
      if (e.m[2]) cmp({e.name, ".b.dbg"}, dbg_b, e.dbg);
      cmp({e.name, ".b.stall"}, 64'(stall_b), 64'(e.stall));
      cmp({e.name, ".b.busy"}, 64'(busy_b), 64'(e.busy[15:0]));
      cmp({e.name, ".b.cnt"}, 64'(cnt_b), 64'(e.cnt));
    end
  end

  task automatic drv(input logic w, input logic [4:0] a, input logic [63:0] d,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dr,
                     input logic iv, input logic [4:0] ir);
    @(posedge clk);
    #1;
    we = w; wa = a; wdata = d; ra0 = r0; ra1 = r1; dbg_ra = dr;
    issue_valid = iv; issue_rd = ir;
  endtask

  task automatic expect_(input string nm, input logic [2:0] m, input logic [63:0] e0,
                         input logic [63:0] e1, input logic [63:0] ed, input logic st,
                         input logic [31:0] bz, input int c);
    exp_t e;
    e.name = nm; e.m = m; e.rd0 = e0; e.rd1 = e1; e.dbg = ed;
    e.stall = st; e.busy = bz; e.cnt = c;
    q.push_back(e);
  endtask

  localparam logic [63:0] D5  = 64'h0123_4567_DEAD_BEEF;
  localparam logic [63:0] AA  = 64'h5A5A_5A5A_A5A5_A5A5;
  localparam logic [63:0] W3  = 64'h3333_0000_1111_2222;
  localparam logic [63:0] W4  = 64'h4444_5555_6666_7777;

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);            expect_("rst",        7, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 reset = 1;
    drv(1, 5, D5, 5, 0, 5, 0, 0);           expect_("wr_byp",     7, D5, 0, 0, 0, 0, 0);
    drv(0, 5, 0, 5, 0, 5, 0, 0);            expect_("wr_store",   5, D5, 0, D5, 0, 0, 0);
    drv(0, 5, 0, 5, 0, 5, 0, 0);
    #2 reset = 0;                            expect_("async_rst",  5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1 reset = 1;
    drv(1, 0, 64'h1234, 0, 0, 0, 1, 0);     expect_("x0_byp",     7, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            expect_("x0_read",    7, 0, 0, 0, 0, 0, 0);
    drv(1, 7, AA, 0, 7, 7, 0, 0);           expect_("byp_rd1",    6, 0, AA, 0, 0, 0, 0);
    drv(0, 7, 0, 0, 7, 7, 0, 0);            expect_("dbg_new",    6, 0, AA, AA, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 3);            expect_("issue3",     7, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 3, 0, 0, 0, 0);            expect_("stall3",     1, 0, 0, 0, 1, 32'h8, 1);
    drv(1, 3, W3, 3, 0, 0, 0, 0);           expect_("wr_unstall", 1, W3, 0, 0, 0, 32'h8, 1);
    drv(0, 0, 0, 3, 0, 0, 0, 0);            expect_("cleared3",   1, W3, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 4);            expect_("issue4",     0, 0, 0, 0, 0, 0, 0);
    drv(1, 4, W4, 4, 0, 0, 1, 4);           expect_("set_clr",    1, W4, 0, 0, 0, 32'h10, 1);
    drv(0, 0, 0, 4, 0, 4, 0, 0);            expect_("set_wins",   5, W4, 0, W4, 1, 32'h10, 1);
    drv(1, 4, 64'h44, 0, 0, 0, 0, 0);       expect_("clr4_pre",   0, 0, 0, 0, 0, 32'h10, 1);
    drv(0, 0, 0, 0, 0, 4, 0, 0);            expect_("clr4",       4, 0, 0, 64'h44, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 2);            expect_("issue2",     0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 2, 0, 1, 9);            expect_("stall_gate", 0, 0, 0, 0, 1, 32'h4, 1);
    drv(0, 0, 0, 0, 0, 0, 1, 6);            expect_("no_set9",    0, 0, 0, 0, 0, 32'h4, 1);
    drv(0, 0, 0, 0, 0, 0, 1, 6);            expect_("waw6",       0, 0, 0, 0, 0, 32'h44, 2);
    drv(1, 2, 64'h22, 0, 0, 0, 1, 9);       expect_("waw_keep",   0, 0, 0, 0, 0, 32'h44, 2);
    drv(1, 6, 64'h66, 0, 0, 0, 0, 0);       expect_("swap",       0, 0, 0, 0, 0, 32'h240, 2);
    drv(1, 10, 64'hAA, 0, 0, 10, 0, 0);     expect_("clr6",       4, 0, 0, 0, 0, 32'h200, 1);
    drv(1, 9, 64'h99, 10, 0, 0, 0, 0);      expect_("nonbusy_wr", 1, 64'hAA, 0, 0, 0, 32'h200, 1);
    drv(0, 0, 0, 9, 0, 0, 0, 0);            expect_("final",      1, 64'h99, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
